// File: rtl/lc4_alu_iter.sv
// Multi-cycle LC4 execute-stage ALU: single-cycle ops register on accept, DIV/MOD iterate W cycles.
// Optional macro LC4_ALU_ITER_MUL_EN moves MUL onto a W-cycle shift-add unit instead of a combinational multiplier.
module lc4_alu_iter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [15:0]  i_insn,
  input  logic [W-1:0] i_pc,
  input  logic [W-1:0] i_r1data,
  input  logic [W-1:0] i_r2data,
  output logic         o_valid,
  output logic [W-1:0] o_result
);

`ifdef LC4_ALU_ITER_MUL_EN
  typedef enum logic [1:0] {IDLE, DIV, MUL} state_t;
`else
  typedef enum logic [1:0] {IDLE, DIV} state_t;
`endif

  localparam int CW = $clog2(W) + 1;

  state_t        state;
  logic [W-1:0]  opA, opB, acc;
  logic          wantRem;
  logic [CW-1:0] iterCount;
  logic          lastIter;

  logic [3:0]    opcode;
  logic [W-1:0]  sextImm5, sextImm6, sextImm7, sextImm9, sextImm11, zextImm7;
  logic          isDivMod, startDiv;
  logic [W-1:0]  cmpB, cmpRes, sraRes, mulProd, jsrTarget, aluResult;
  logic          cmpSigned, cmpLt;

  assign opcode    = i_insn[15:12];
  assign sextImm5  = {{(W-5){i_insn[4]}}, i_insn[4:0]};
  assign sextImm6  = {{(W-6){i_insn[5]}}, i_insn[5:0]};
  assign sextImm7  = {{(W-7){i_insn[6]}}, i_insn[6:0]};
  assign sextImm9  = {{(W-9){i_insn[8]}}, i_insn[8:0]};
  assign sextImm11 = {{(W-11){i_insn[10]}}, i_insn[10:0]};
  assign zextImm7  = {{(W-7){1'b0}}, i_insn[6:0]};
  assign jsrTarget = W'({i_pc[15], i_insn[10:0], 4'b0000});
  assign sraRes    = $signed(i_r1data) >>> i_insn[3:0];

  assign isDivMod = (opcode == 4'h1 && i_insn[5:3] == 3'b011) ||
                    (opcode == 4'hA && i_insn[5:4] == 2'b11);
  // A zero divisor completes as a single-cycle op with result 0.
  assign startDiv = isDivMod && (i_r2data != '0);

`ifdef LC4_ALU_ITER_MUL_EN
  logic isMulOp;
  assign isMulOp = (opcode == 4'h1) && (i_insn[5:3] == 3'b001);
  assign mulProd = '0;
`else
  assign mulProd = i_r1data * i_r2data;
`endif

  always_comb begin
    cmpB      = i_r2data;
    cmpSigned = 1'b1;
    case (i_insn[8:7])
      2'b00:   begin cmpB = i_r2data; cmpSigned = 1'b1; end
      2'b01:   begin cmpB = i_r2data; cmpSigned = 1'b0; end
      2'b10:   begin cmpB = sextImm7; cmpSigned = 1'b1; end
      default: begin cmpB = zextImm7; cmpSigned = 1'b0; end
    endcase
  end

  assign cmpLt  = cmpSigned ? ($signed(i_r1data) < $signed(cmpB)) : (i_r1data < cmpB);
  assign cmpRes = (i_r1data == cmpB) ? '0 : (cmpLt ? '1 : W'(1));

  always_comb begin
    aluResult = '0;
    case (opcode)
      4'h0: aluResult = (i_insn[11:9] == 3'b000) ? i_pc : i_pc + W'(1) + sextImm9;
      4'h1: begin
        if (i_insn[5]) aluResult = i_r1data + sextImm5;
        else begin
          case (i_insn[4:3])
            2'b00:   aluResult = i_r1data + i_r2data;
            2'b01:   aluResult = mulProd;
            2'b10:   aluResult = i_r1data - i_r2data;
            default: aluResult = '0;
          endcase
        end
      end
      4'h2: aluResult = cmpRes;
      4'h4: aluResult = i_insn[11] ? jsrTarget : i_r1data;
      4'h5: begin
        if (i_insn[5]) aluResult = i_r1data & sextImm5;
        else begin
          case (i_insn[4:3])
            2'b00:   aluResult = i_r1data & i_r2data;
            2'b01:   aluResult = ~i_r1data;
            2'b10:   aluResult = i_r1data | i_r2data;
            default: aluResult = i_r1data ^ i_r2data;
          endcase
        end
      end
      4'h6, 4'h7: aluResult = i_r1data + sextImm6;
      4'h8: aluResult = i_r1data;
      4'h9: aluResult = sextImm9;
      4'hA: begin
        case (i_insn[5:4])
          2'b00:   aluResult = i_r1data << i_insn[3:0];
          2'b01:   aluResult = sraRes;
          2'b10:   aluResult = i_r1data >> i_insn[3:0];
          default: aluResult = '0;
        endcase
      end
      4'hC: aluResult = i_insn[11] ? i_pc + W'(1) + sextImm11 : i_r1data;
      4'hD: aluResult = (i_r1data & ~W'(16'hFF00)) | (W'(i_insn[7:0]) << 8);
      4'hF: aluResult = W'({8'h80, i_insn[7:0]});
      default: aluResult = '0;
    endcase
  end

  // Restoring step: remainder stays below the divisor, so W-bit wrap-around subtraction is exact.
  logic [W:0]   divShift;
  logic         divGe;
  logic [W-1:0] divRemNext, divQuoNext;
  assign divShift   = {acc, opA[W-1]};
  assign divGe      = divShift >= {1'b0, opB};
  assign divRemNext = divGe ? divShift[W-1:0] - opB : divShift[W-1:0];
  assign divQuoNext = {opA[W-2:0], divGe};

`ifdef LC4_ALU_ITER_MUL_EN
  logic [W-1:0] mulAccNext;
  assign mulAccNext = acc + (opA[0] ? opB : '0);
`endif

  assign lastIter = (iterCount == CW'(W - 1));
  assign o_ready  = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      o_valid   <= 1'b0;
      o_result  <= '0;
      opA       <= '0;
      opB       <= '0;
      acc       <= '0;
      wantRem   <= 1'b0;
      iterCount <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid) begin
            iterCount <= '0;
            acc       <= '0;
            opA       <= i_r1data;
            opB       <= i_r2data;
            wantRem   <= (opcode == 4'hA);
            if (startDiv) state <= DIV;
`ifdef LC4_ALU_ITER_MUL_EN
            else if (isMulOp) state <= MUL;
`endif
            else begin
              o_result <= aluResult;
              o_valid  <= 1'b1;
            end
          end
        end
        DIV: begin
          acc       <= divRemNext;
          opA       <= divQuoNext;
          iterCount <= iterCount + CW'(1);
          if (lastIter) begin
            o_result <= wantRem ? divRemNext : divQuoNext;
            o_valid  <= 1'b1;
            state    <= IDLE;
          end
        end
`ifdef LC4_ALU_ITER_MUL_EN
        MUL: begin
          acc       <= mulAccNext;
          opA       <= opA >> 1;
          opB       <= opB << 1;
          iterCount <= iterCount + CW'(1);
          if (lastIter) begin
            o_result <= mulAccNext;
            o_valid  <= 1'b1;
            state    <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
